// File: rtl/instruction_fetch.sv
// RV32I fetch stage: owns the PC, keeps one instruction-memory request in flight and
// hands {out_instr, out_pc, out_valid} to decode, honouring stall and execute redirects.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_valid
);

    typedef enum logic [1:0] {
        StFetch,
        StWait,
        StHold
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic        drop_q;
    logic [31:0] skid_instr_q;
    logic [31:0] skid_pc_q;
    logic [31:0] out_instr_q;
    logic [31:0] out_pc_q;
    logic        out_valid_q;

    logic        slot_free;
    logic        consumed;
    logic [31:0] pc_inc;
    logic [31:0] redirect_target;

    assign slot_free       = !out_valid_q || !stall;
    assign consumed        = out_valid_q && !stall;
    assign pc_inc          = pc_q + 32'd4;
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

    assign imem_req  = (state_q == StFetch) && !rst;
    assign imem_addr = pc_q;

    assign out_instr = out_instr_q;
    assign out_pc    = out_pc_q;
    assign out_valid = out_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StFetch;
            pc_q         <= RESET_PC;
            drop_q       <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= 32'h0;
            out_instr_q  <= NOP_INSTR;
            out_pc_q     <= 32'h0;
            out_valid_q  <= 1'b0;
        end else if (redirect_valid) begin
            // Flush the output slot and skid; an in-flight response is marked for discard.
            pc_q        <= redirect_target;
            out_valid_q <= 1'b0;
            out_instr_q <= NOP_INSTR;
            case (state_q)
                StFetch: begin
                    if (imem_ready) begin
                        state_q <= StWait;
                        drop_q  <= 1'b1;
                    end
                end
                StWait: begin
                    if (imem_rvalid) begin
                        state_q <= StFetch;
                        drop_q  <= 1'b0;
                    end else begin
                        drop_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StFetch;
                end
            endcase
        end else begin
            // Loads below override this when the slot is refilled on the same edge.
            if (consumed) begin
                out_valid_q <= 1'b0;
                out_instr_q <= NOP_INSTR;
            end
            case (state_q)
                StFetch: begin
                    if (imem_ready) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (imem_rvalid) begin
                        if (drop_q) begin
                            drop_q  <= 1'b0;
                            state_q <= StFetch;
                        end else if (slot_free) begin
                            out_instr_q <= imem_rdata;
                            out_pc_q    <= pc_q;
                            out_valid_q <= 1'b1;
                            pc_q        <= pc_inc;
                            state_q     <= StFetch;
                        end else begin
                            skid_instr_q <= imem_rdata;
                            skid_pc_q    <= pc_q;
                            pc_q         <= pc_inc;
                            state_q      <= StHold;
                        end
                    end
                end
                default: begin
                    if (slot_free) begin
                        out_instr_q <= skid_instr_q;
                        out_pc_q    <= skid_pc_q;
                        out_valid_q <= 1'b1;
                        state_q     <= StFetch;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a latency-randomised memory model plus an in-order stream model
// (next expected PC, reset/redirect retargeting) checks every instruction decode consumes.
module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_valid;

    instruction_fetch #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_valid      (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory model state: at most one response pending.
    int          ready_pct = 100;
    int          lat_min = 1;
    int          lat_max = 1;
    logic        pend_valid = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          pend_wait = 0;

    // Stream model and observations.
    logic [31:0] model_pc = RESET_PC;
    logic [31:0] got_pc[$];
    logic [31:0] got_instr[$];
    logic [31:0] want_pc[$];
    logic [31:0] want_instr[$];
    int          nop_viol = 0;
    int          align_viol = 0;
    int          proto_viol = 0;
    int          req_rst_viol = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h0000_0013;
    endfunction

    // One clock cycle: entered and left at a falling edge with inputs already driven.
    task automatic tick();
        logic        rv;
        logic        acc;
        logic [31:0] acc_addr;
        imem_ready  = ($urandom_range(99) < ready_pct);
        rv          = pend_valid && (pend_wait == 0);
        imem_rvalid = rv;
        imem_rdata  = rv ? mem_word(pend_addr) : $urandom();
        #1;
        if (imem_addr[1:0] != 2'b00) align_viol++;
        if (!out_valid && out_instr !== NOP_INSTR) nop_viol++;
        if (rst && imem_req) req_rst_viol++;
        acc      = imem_req && imem_ready;
        acc_addr = imem_addr;
        if (acc && pend_valid) proto_viol++;
        if (!rst && out_valid && !stall) begin
            got_pc.push_back(out_pc);
            got_instr.push_back(out_instr);
            want_pc.push_back(model_pc);
            want_instr.push_back(mem_word(model_pc));
            model_pc = model_pc + 32'd4;
        end
        if (rst) model_pc = RESET_PC;
        else if (redirect_valid) model_pc = redirect_pc & 32'hFFFF_FFFC;
        @(posedge clk);
        if (rv) pend_valid = 1'b0;
        else if (pend_valid) pend_wait--;
        if (acc) begin
            pend_valid = 1'b1;
            pend_addr  = acc_addr;
            pend_wait  = int'($urandom_range(lat_max, lat_min)) - 1;
        end
        @(negedge clk);
    endtask

    task automatic clear_obs();
        got_pc.delete();
        got_instr.delete();
        want_pc.delete();
        want_instr.delete();
    endtask

    task automatic do_reset();
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        ready_pct      = 100;
        lat_min        = 1;
        lat_max        = 1;
        pend_valid     = 1'b0;
        rst            = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        clear_obs();
    endtask

    task automatic test_reset();
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        ready_pct      = 100;
        rst            = 1'b1;
        tick();
        tick();
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_req: got %b expected 0", imem_req);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (out_instr !== NOP_INSTR) begin
            errors++;
            $display("FAIL reset_instr: got %h expected %h", out_instr, NOP_INSTR);
        end
        checks++;
        if (out_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_out_pc: got %h expected 0", out_pc);
        end
        checks++;
        if (imem_addr !== RESET_PC) begin
            errors++;
            $display("FAIL reset_addr: got %h expected %h", imem_addr, RESET_PC);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_req: got %b expected 1", imem_req);
        end
        clear_obs();
    endtask

    task automatic test_first_fetch();
        do_reset();
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h0050_0093) begin
            errors++;
            $display("FAIL first_fetch: got v=%b pc=%h instr=%h expected v=1 pc=0 instr=00500093",
                     out_valid, out_pc, out_instr);
        end
        checks++;
        if (imem_addr !== 32'h4) begin
            errors++;
            $display("FAIL first_next_addr: got %h expected 4", imem_addr);
        end
    endtask

    task automatic test_steady();
        do_reset();
        for (int i = 0; i < 17; i++) tick();
        checks++;
        if (got_pc.size() != 8) begin
            errors++;
            $display("FAIL steady_count: got %0d expected 8", got_pc.size());
        end
        for (int i = 0; i < got_pc.size(); i++) begin
            checks++;
            if (got_pc[i] !== 32'(i * 4) || got_instr[i] !== mem_word(32'(i * 4))) begin
                errors++;
                $display("FAIL steady[%0d]: got pc=%h instr=%h expected pc=%h instr=%h", i,
                         got_pc[i], got_instr[i], 32'(i * 4), mem_word(32'(i * 4)));
            end
        end
        clear_obs();
    endtask

    task automatic test_stall();
        do_reset();
        tick();
        tick();
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== mem_word(32'h0)
                || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v=%b pc=%h instr=%h req=%b expected v=1 pc=0 req=0",
                         i, out_valid, out_pc, out_instr, imem_req);
            end
        end
        stall = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h4 || out_instr !== mem_word(32'h4)) begin
            errors++;
            $display("FAIL stall_skid: got v=%b pc=%h instr=%h expected v=1 pc=4 instr=%h",
                     out_valid, out_pc, out_instr, mem_word(32'h4));
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            errors++;
            $display("FAIL stall_resume: got req=%b addr=%h expected req=1 addr=8",
                     imem_req, imem_addr);
        end
        clear_obs();
    endtask

    task automatic test_redirect_wait();
        do_reset();
        lat_min = 2;
        lat_max = 2;
        tick();
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL rw_waiting: got req=%b expected 0", imem_req);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL rw_refetch: got v=%b req=%b addr=%h expected v=0 req=1 addr=100",
                     out_valid, imem_req, imem_addr);
        end
        for (int i = 0; i < 50 && got_pc.size() == 0; i++) tick();
        checks++;
        if (got_pc.size() == 0) begin
            errors++;
            $display("FAIL rw_timeout: got no instruction expected pc=100");
        end else if (got_pc[0] !== 32'h100 || got_instr[0] !== mem_word(32'h100)) begin
            errors++;
            $display("FAIL rw_target: got pc=%h instr=%h expected pc=100 instr=%h",
                     got_pc[0], got_instr[0], mem_word(32'h100));
        end
        clear_obs();
    endtask

    task automatic test_redirect_accept();
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h200 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ra_drop: got req=%b addr=%h v=%b expected req=0 addr=200 v=0",
                     imem_req, imem_addr, out_valid);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ra_refetch: got req=%b addr=%h v=%b expected req=1 addr=200 v=0",
                     imem_req, imem_addr, out_valid);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 50 && !out_valid; i++) tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC || out_instr !== mem_word(32'hFFFF_FFFC)
            || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL ra_wrap: got v=%b pc=%h instr=%h addr=%h expected v=1 pc=fffffffc addr=0",
                     out_valid, out_pc, out_instr, imem_addr);
        end
        clear_obs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        lat_min = 3;
        lat_max = 3;
        tick();
        rst       = 1'b1;
        ready_pct = 0;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL rm_req_in_reset: got %b expected 0", imem_req);
        end
        tick();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_instr !== NOP_INSTR || imem_addr !== RESET_PC
            || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL rm_late_rvalid: got v=%b instr=%h addr=%h req=%b expected v=0 instr=%h addr=%h req=1",
                     out_valid, out_instr, imem_addr, imem_req, NOP_INSTR, RESET_PC);
        end
        ready_pct = 100;
        lat_min   = 1;
        lat_max   = 1;
        for (int i = 0; i < 50 && got_pc.size() == 0; i++) tick();
        checks++;
        if (got_pc.size() == 0) begin
            errors++;
            $display("FAIL rm_timeout: got no instruction expected pc=%h", RESET_PC);
        end else if (got_pc[0] !== RESET_PC || got_instr[0] !== mem_word(RESET_PC)) begin
            errors++;
            $display("FAIL rm_restart: got pc=%h instr=%h expected pc=%h instr=%h",
                     got_pc[0], got_instr[0], RESET_PC, mem_word(RESET_PC));
        end
        clear_obs();
    endtask

    task automatic test_random();
        do_reset();
        ready_pct = 60;
        lat_min   = 1;
        lat_max   = 3;
        for (int i = 0; i < 2000; i++) begin
            stall          = ($urandom_range(99) < 30);
            redirect_valid = ($urandom_range(99) < 4);
            redirect_pc    = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(15)
                                                      : $urandom();
            tick();
        end
        stall          = 1'b0;
        redirect_valid = 1'b0;
        ready_pct      = 100;
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (got_pc.size() < 100) begin
            errors++;
            $display("FAIL rand_count: got %0d expected at least 100", got_pc.size());
        end
        for (int i = 0; i < got_pc.size(); i++) begin
            checks++;
            if (got_pc[i] !== want_pc[i] || got_instr[i] !== want_instr[i]) begin
                errors++;
                $display("FAIL rand[%0d]: got pc=%h instr=%h expected pc=%h instr=%h", i,
                         got_pc[i], got_instr[i], want_pc[i], want_instr[i]);
            end
        end
        clear_obs();
    endtask

    task automatic test_protocol();
        checks++;
        if (proto_viol != 0) begin
            errors++;
            $display("FAIL proto_outstanding: got %0d extra requests expected 0", proto_viol);
        end
        checks++;
        if (nop_viol != 0) begin
            errors++;
            $display("FAIL proto_nop: got %0d non-NOP idle cycles expected 0", nop_viol);
        end
        checks++;
        if (align_viol != 0) begin
            errors++;
            $display("FAIL proto_align: got %0d unaligned addresses expected 0", align_viol);
        end
        checks++;
        if (req_rst_viol != 0) begin
            errors++;
            $display("FAIL proto_req_rst: got %0d requests in reset expected 0", req_rst_viol);
        end
    endtask

    initial begin
        rst            = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_ready     = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        @(negedge clk);
        test_reset();
        test_first_fetch();
        test_steady();
        test_stall();
        test_redirect_wait();
        test_redirect_accept();
        test_reset_mid();
        test_random();
        test_protocol();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish before 1ms");
        $fatal(1, "timeout");
    end

endmodule
